timer_seq_ctrl: RTL and testbench

- Upstream command sequencer for the `timer` block.
- Buffers a queue of load values pushed over a valid/ready interface.
- Issues each value to the timer as a one-cycle `start` pulse with `load_Val` held stable, waits for the timer's `done`, then launches the next entry.
- Signals when the queue has fully drained.

---
 rtl/timer_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_timer_seq_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_seq_ctrl.sv
// ---------------------------------------------------------------------------
// timer_seq_ctrl
//
// Command sequencer that sits upstream of the `timer` block. Load values are
// queued in a small circular FIFO through a valid/ready port. Each non-zero
// entry is handed to the timer as a one-cycle start pulse, with the load value
// held steady until the timer reports done. A zero entry is dropped without a
// run. A one-cycle seq_done pulse marks the point where a run finishes and
// nothing is left to launch.
//
// Build option:
//   TIMER_SEQ_REPEAT_EN - adds input i_repeat. When it is high as a run
//                         completes, the value just run is written back at
//                         the FIFO tail, so the queue loops.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst            synchronous active-high reset
//   i_in_valid       producer offers i_in_val
//   i_in_val         load value to queue
//   o_in_ready       queue can accept (push = valid & ready)
//   i_enable         permits launching new runs
//   o_tmr_start      one-cycle start pulse to the timer
//   o_tmr_load_Val   load value to the timer, held for the whole run
//   i_tmr_done       timer done (pulse or level; only the rising edge counts)
//   i_repeat         (TIMER_SEQ_REPEAT_EN only) recirculate completed entries
//   o_busy           high whenever a run is in progress (state != IDLE)
//   o_seq_done       one-cycle pulse: run finished and queue empty
//   o_level          current queue occupancy
// ---------------------------------------------------------------------------
module timer_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_in_valid,
  input  logic [WIDTH-1:0]         i_in_val,
  output logic                     o_in_ready,
  input  logic                     i_enable,
  output logic                     o_tmr_start,
  output logic [WIDTH-1:0]         o_tmr_load_Val,
  input  logic                     i_tmr_done,
`ifdef TIMER_SEQ_REPEAT_EN
  input  logic                     i_repeat,
`endif
  output logic                     o_busy,
  output logic                     o_seq_done,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_GAP
  } state_t;

  state_t             r_state;
  state_t             w_nextState;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [PW-1:0]      r_wrPtr;
  logic [PW-1:0]      r_rdPtr;
  logic [LW-1:0]      r_level;
  logic               r_doneQ;
  logic               r_start;
  logic [WIDTH-1:0]   r_loadVal;
  logic               r_seqDone;

  logic               w_doneRise;
  logic               w_full;
  logic               w_empty;
  logic [WIDTH-1:0]   w_head;
  logic               w_recircReq;
  logic               w_recirc;
  logic               w_push;
  logic               w_pop;
  logic               w_launch;
  logic               w_wrEn;
  logic [WIDTH-1:0]   w_wrData;
  logic               w_finish;

  // A done held high from the previous run must not look like a new
  // completion, so only a low-to-high transition ends a run.
  assign w_doneRise = i_tmr_done & ~r_doneQ;

  assign w_full  = (r_level == LEVEL_FULL);
  assign w_empty = (r_level == '0);
  assign w_head  = r_mem[r_rdPtr];

`ifdef TIMER_SEQ_REPEAT_EN
  // Completed value goes back to the tail. If producers refilled the queue
  // during the run there is no slot left, and the value is dropped.
  assign w_recircReq = (r_state == S_WAIT) & w_doneRise & i_repeat;
  assign w_recirc    = w_recircReq & ~w_full;
  assign w_finish    = (r_state == S_WAIT) & w_doneRise & w_empty & ~w_push & ~i_repeat;
`else
  assign w_recircReq = 1'b0;
  assign w_recirc    = 1'b0;
  assign w_finish    = (r_state == S_WAIT) & w_doneRise & w_empty & ~w_push;
`endif

  // Ready looks only at the registered level, so a pop on the same edge
  // never frees a slot early. The recirculation write takes the only write
  // port, so producers are held off in that cycle.
  assign o_in_ready = ~w_full & ~w_recircReq;
  assign w_push     = i_in_valid & o_in_ready;
  assign w_wrEn     = w_push | w_recirc;
  assign w_wrData   = w_recirc ? r_loadVal : i_in_val;

  // State register for the launch FSM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. In IDLE the head is popped whenever launching is
  // allowed. A zero head is simply thrown away, and the FSM stays in IDLE to
  // look at the next entry. ARM is the single start cycle. GAP keeps start
  // low for at least one cycle between runs.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    w_launch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_enable && !w_empty) begin
          w_pop = 1'b1;
          if (w_head != '0) begin
            w_launch    = 1'b1;
            w_nextState = S_ARM;
          end
        end
      end
      S_ARM:  w_nextState = S_WAIT;
      S_WAIT: begin
        if (w_doneRise) begin
          w_nextState = S_GAP;
        end
      end
      S_GAP:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // FIFO bookkeeping, done edge tracking and registered timer-facing outputs.
  // The start pulse is registered off the launch decision, so it lines up
  // with the ARM cycle. A launch comes only from IDLE, so start can never be
  // high on two consecutive cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_level   <= '0;
      r_doneQ   <= 1'b0;
      r_start   <= 1'b0;
      r_loadVal <= '0;
      r_seqDone <= 1'b0;
    end else begin
      r_doneQ   <= i_tmr_done;
      r_start   <= w_launch;
      r_seqDone <= w_finish;
      if (w_launch) begin
        r_loadVal <= w_head;
      end
      if (w_wrEn) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      r_level <= r_level + LW'(w_wrEn) - LW'(w_pop);
    end
  end

  // Storage array. It has no reset because the pointers define which
  // entries are valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_wrEn) begin
      r_mem[r_wrPtr] <= w_wrData;
    end
  end

  assign o_tmr_start    = r_start;
  assign o_tmr_load_Val = r_loadVal;
  assign o_busy         = (r_state != S_IDLE);
  assign o_seq_done     = r_seqDone;
  assign o_level        = r_level;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_seq_ctrl
//
// Directed bench for timer_seq_ctrl. A behavioural timer answers each start
// with a one-cycle done pulse a fixed number of cycles after the start. The
// delay depends on the load value. An extra bench-driven done term lets a
// scenario hold done as a level.
// A posedge monitor records the start values and seq_done pulses. It also
// counts two kinds of protocol breakage: back-to-back start cycles, and a
// load value that changes during a run. Scenario tasks compare these records
// against hand-computed expectations.
// Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_timer_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       inValid;
  logic [7:0] inVal;
  logic       inReady;
  logic       enable;
  logic       tmrStart;
  logic [7:0] tmrLoad;
  logic       tmrDone;
  logic       busy;
  logic       seqDone;
  logic [2:0] level;
`ifdef TIMER_SEQ_REPEAT_EN
  logic       repeatIn;
`endif

  logic       modelDone;
  logic       tbDone;
  logic       tmRun;
  logic [7:0] tmCnt;

  int checks;
  int errors;

  logic [7:0] startLog[$];
  int         consecStart;
  int         loadChg;
  int         seqDoneCount;
  logic       prevStart;
  logic       prevBusy;
  logic [7:0] prevLoad;

  assign tmrDone = modelDone | tbDone;

  timer_seq_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_in_valid     (inValid),
    .i_in_val       (inVal),
    .o_in_ready     (inReady),
    .i_enable       (enable),
    .o_tmr_start    (tmrStart),
    .o_tmr_load_Val (tmrLoad),
    .i_tmr_done     (tmrDone),
`ifdef TIMER_SEQ_REPEAT_EN
    .i_repeat       (repeatIn),
`endif
    .o_busy         (busy),
    .o_seq_done     (seqDone),
    .o_level        (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural timer. After a start with load N, the counter steps down once
  // per cycle, and done pulses for one cycle when the count reaches 1.
  always @(posedge clk) begin
    modelDone <= 1'b0;
    if (rst) begin
      tmRun <= 1'b0;
      tmCnt <= 8'd0;
    end else if (tmrStart) begin
      tmCnt <= tmrLoad;
      tmRun <= 1'b1;
    end else if (tmRun) begin
      if (tmCnt == 8'd1) begin
        tmRun     <= 1'b0;
        modelDone <= 1'b1;
      end else begin
        tmCnt <= tmCnt - 8'd1;
      end
    end
  end

  // Monitor: records the value of each cycle that has just ended.
  initial begin
    consecStart  = 0;
    loadChg      = 0;
    seqDoneCount = 0;
    prevStart    = 1'b0;
    prevBusy     = 1'b0;
    prevLoad     = 8'd0;
  end

  always @(posedge clk) begin
    if (tmrStart === 1'b1) startLog.push_back(tmrLoad);
    if (tmrStart === 1'b1 && prevStart === 1'b1) consecStart++;
    if (busy === 1'b1 && prevBusy === 1'b1 && tmrLoad !== prevLoad) loadChg++;
    if (seqDone === 1'b1) seqDoneCount++;
    prevStart = tmrStart;
    prevBusy  = busy;
    prevLoad  = tmrLoad;
  end

  // Drives one value for one cycle. Accepted reports whether ready was high
  // at the edge where the push would happen.
  task automatic pushVal(input logic [7:0] v, output bit accepted);
    inValid  = 1'b1;
    inVal    = v;
    accepted = inReady;
    @(negedge clk);
    inValid  = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    inValid = 1'b0;
    inVal   = 8'd0;
    enable  = 1'b0;
    tbDone  = 1'b0;
`ifdef TIMER_SEQ_REPEAT_EN
    repeatIn = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++; if (tmrStart !== 1'b0) begin errors++; $display("[TB] FAIL reset_start got %0b exp 0", tmrStart); end
    checks++; if (tmrLoad !== 8'd0) begin errors++; $display("[TB] FAIL reset_load got %0d exp 0", tmrLoad); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (seqDone !== 1'b0) begin errors++; $display("[TB] FAIL reset_seqdone got %0b exp 0", seqDone); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %0b exp 1", inReady); end
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level got %0d exp 0", level); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int base, sdBase, k;
    bit acc;
    base   = startLog.size();
    sdBase = seqDoneCount;
    enable = 1'b1;
    pushVal(8'd5, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("[TB] FAIL single_accept got %0b exp 1", acc); end
    checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL single_level_after_push got %0d exp 1", level); end
    checks++; if (tmrStart !== 1'b0) begin errors++; $display("[TB] FAIL single_no_early_start got %0b exp 0", tmrStart); end
    @(negedge clk);
    checks++; if (tmrStart !== 1'b1) begin errors++; $display("[TB] FAIL single_start got %0b exp 1", tmrStart); end
    checks++; if (tmrLoad !== 8'd5) begin errors++; $display("[TB] FAIL single_load got %0d exp 5", tmrLoad); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_arm got %0b exp 1", busy); end
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL single_level_after_pop got %0d exp 0", level); end
    @(negedge clk);
    checks++; if (tmrStart !== 1'b0) begin errors++; $display("[TB] FAIL single_start_one_cycle got %0b exp 0", tmrStart); end
    checks++; if (tmrLoad !== 8'd5) begin errors++; $display("[TB] FAIL single_load_held got %0d exp 5", tmrLoad); end
    k = 0;
    while (seqDone !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k !== 6) begin errors++; $display("[TB] FAIL single_done_latency got %0d cycles exp 6", k); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_gap got %0b exp 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_after_gap got %0b exp 0", busy); end
    checks++; if (seqDone !== 1'b0) begin errors++; $display("[TB] FAIL single_seqdone_pulse got %0b exp 0", seqDone); end
    @(negedge clk);
    checks++; if (startLog.size() - base !== 1) begin errors++; $display("[TB] FAIL single_start_count got %0d exp 1", startLog.size() - base); end
    checks++; if (seqDoneCount - sdBase !== 1) begin errors++; $display("[TB] FAIL single_seqdone_count got %0d exp 1", seqDoneCount - sdBase); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [4];
    int base, sdBase, csBase, lcBase, k;
    bit acc;
    vals   = '{8'd5, 8'd3, 8'd7, 8'd2};
    base   = startLog.size();
    sdBase = seqDoneCount;
    csBase = consecStart;
    lcBase = loadChg;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pushVal(vals[i], acc);
      checks++; if (acc !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept_%0d got %0b exp 1", i, acc); end
    end
    checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL b2b_level_full got %0d exp 4", level); end
    checks++; if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_full got %0b exp 0", inReady); end
    pushVal(8'd9, acc);
    checks++; if (acc !== 1'b0) begin errors++; $display("[TB] FAIL b2b_fifth_refused got %0b exp 0", acc); end
    checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL b2b_level_after_refuse got %0d exp 4", level); end
    enable = 1'b1;
    k = 0;
    while (seqDoneCount == sdBase && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k >= 300) begin errors++; $display("[TB] FAIL b2b_drain_timeout got %0d cycles exp <300", k); end
    repeat (3) @(negedge clk);
    checks++; if (startLog.size() - base !== 4) begin errors++; $display("[TB] FAIL b2b_start_count got %0d exp 4", startLog.size() - base); end
    for (int i = 0; i < 4; i++) begin
      if (startLog.size() > base + i) begin
        checks++; if (startLog[base + i] !== vals[i]) begin errors++; $display("[TB] FAIL b2b_order_%0d got %0d exp %0d", i, startLog[base + i], vals[i]); end
      end
    end
    checks++; if (consecStart - csBase !== 0) begin errors++; $display("[TB] FAIL b2b_start_gap got %0d back-to-back exp 0", consecStart - csBase); end
    checks++; if (loadChg - lcBase !== 0) begin errors++; $display("[TB] FAIL b2b_load_stable got %0d changes exp 0", loadChg - lcBase); end
    checks++; if (seqDoneCount - sdBase !== 1) begin errors++; $display("[TB] FAIL b2b_seqdone_count got %0d exp 1", seqDoneCount - sdBase); end
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL b2b_level_end got %0d exp 0", level); end
  endtask

  task automatic test_zero_entry();
    int base, sdBase, k;
    bit acc;
    base   = startLog.size();
    sdBase = seqDoneCount;
    enable = 1'b0;
    pushVal(8'd4, acc);
    pushVal(8'd0, acc);
    pushVal(8'd6, acc);
    checks++; if (level !== 3'd3) begin errors++; $display("[TB] FAIL zero_level_queued got %0d exp 3", level); end
    enable = 1'b1;
    k = 0;
    while (seqDoneCount == sdBase && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k >= 300) begin errors++; $display("[TB] FAIL zero_drain_timeout got %0d cycles exp <300", k); end
    repeat (3) @(negedge clk);
    checks++; if (startLog.size() - base !== 2) begin errors++; $display("[TB] FAIL zero_start_count got %0d exp 2", startLog.size() - base); end
    if (startLog.size() >= base + 2) begin
      checks++; if (startLog[base] !== 8'd4) begin errors++; $display("[TB] FAIL zero_first got %0d exp 4", startLog[base]); end
      checks++; if (startLog[base + 1] !== 8'd6) begin errors++; $display("[TB] FAIL zero_second got %0d exp 6", startLog[base + 1]); end
    end
    checks++; if (seqDoneCount - sdBase !== 1) begin errors++; $display("[TB] FAIL zero_seqdone_count got %0d exp 1", seqDoneCount - sdBase); end
    checks++; if (tmrLoad !== 8'd6) begin errors++; $display("[TB] FAIL zero_last_load got %0d exp 6", tmrLoad); end
  endtask

  task automatic test_done_level();
    int base, sdBase, k;
    bit acc;
    base   = startLog.size();
    sdBase = seqDoneCount;
    enable = 1'b1;
    tbDone = 1'b1;
    pushVal(8'd3, acc);
    repeat (9) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL level_no_early_exit got %0b exp 1", busy); end
    checks++; if (seqDoneCount - sdBase !== 0) begin errors++; $display("[TB] FAIL level_no_seqdone got %0d exp 0", seqDoneCount - sdBase); end
    tbDone = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL level_still_waiting got %0b exp 1", busy); end
    tbDone = 1'b1;
    @(negedge clk);
    tbDone = 1'b0;
    checks++; if (seqDone !== 1'b1) begin errors++; $display("[TB] FAIL level_rise_ends_run got %0b exp 1", seqDone); end
    k = 0;
    while (busy !== 1'b0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k !== 1) begin errors++; $display("[TB] FAIL level_gap_length got %0d exp 1", k); end
    @(negedge clk);
    checks++; if (startLog.size() - base !== 1) begin errors++; $display("[TB] FAIL level_start_count got %0d exp 1", startLog.size() - base); end
  endtask

  task automatic test_reset_mid_run();
    int base;
    bit acc;
    enable = 1'b0;
    pushVal(8'd9, acc);
    pushVal(8'd8, acc);
    pushVal(8'd7, acc);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_busy_before got %0b exp 1", busy); end
    checks++; if (level !== 3'd2) begin errors++; $display("[TB] FAIL rstmid_level_before got %0d exp 2", level); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = startLog.size();
    checks++; if (tmrStart !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_start got %0b exp 0", tmrStart); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy got %0b exp 0", busy); end
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL rstmid_level got %0d exp 0", level); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_ready got %0b exp 1", inReady); end
    repeat (20) @(negedge clk);
    checks++; if (startLog.size() - base !== 0) begin errors++; $display("[TB] FAIL rstmid_no_starts got %0d exp 0", startLog.size() - base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stays_idle got %0b exp 0", busy); end
  endtask

`ifdef TIMER_SEQ_REPEAT_EN
  task automatic test_repeat();
    logic [7:0] expSeq [6];
    int base, sdBase, k;
    bit acc;
    expSeq   = '{8'd3, 8'd2, 8'd3, 8'd2, 8'd3, 8'd2};
    base     = startLog.size();
    sdBase   = seqDoneCount;
    enable   = 1'b0;
    repeatIn = 1'b1;
    pushVal(8'd3, acc);
    pushVal(8'd2, acc);
    enable = 1'b1;
    k = 0;
    while (startLog.size() - base < 6 && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k >= 300) begin errors++; $display("[TB] FAIL repeat_loop_timeout got %0d cycles exp <300", k); end
    for (int i = 0; i < 6; i++) begin
      if (startLog.size() > base + i) begin
        checks++; if (startLog[base + i] !== expSeq[i]) begin errors++; $display("[TB] FAIL repeat_order_%0d got %0d exp %0d", i, startLog[base + i], expSeq[i]); end
      end
    end
    checks++; if (seqDoneCount - sdBase !== 0) begin errors++; $display("[TB] FAIL repeat_no_seqdone got %0d exp 0", seqDoneCount - sdBase); end
    repeatIn = 1'b0;
    k = 0;
    while (seqDoneCount == sdBase && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k >= 300) begin errors++; $display("[TB] FAIL repeat_drain_timeout got %0d cycles exp <300", k); end
    repeat (4) @(negedge clk);
    checks++; if (seqDoneCount - sdBase !== 1) begin errors++; $display("[TB] FAIL repeat_seqdone_once got %0d exp 1", seqDoneCount - sdBase); end
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL repeat_level_end got %0d exp 0", level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL repeat_idle_end got %0b exp 0", busy); end
  endtask
`endif

  initial begin
    #400000;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_entry();
    test_done_level();
    test_reset_mid_run();
`ifdef TIMER_SEQ_REPEAT_EN
    test_repeat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
